reno_cc_engine: RTL and testbench
=================================

Name: reno_cc_engine

Overview:
Multi-flow, registered TCP Reno/NewReno congestion-control engine. It serves all flows from one per-flow context array and sits between the incoming-ACK path and the tx scheduler. It accepts one ACK, timeout or init event per cycle, updates that flow's context and emits one registered decision per event. It adds three things over single-flow combinational logic: explicit per-flow recovery states, NewReno partial-ACK handling, and serial-number sequence comparison.

Parameters:
NUM_FLOWS, 16, flows held in the context array; FLOW_ID_W = clog2(NUM_FLOWS)
SEQ_W, 32, sequence-number width
WIN_W, 9, window/counter width
MAX_WND, 256, window ceiling
INIT_WND, 2, window after reset or INIT
DUP_THRESH, 3, dup ACKs that trigger fast retransmit
MAX_DUP, 15, saturation value of the dup-ACK counter
NEWRENO, 1, 1 = partial ACKs keep fast recovery; 0 = plain Reno

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
evt_valid  in  1  event present
evt_ready  out  1  event accepted when valid&ready
evt_type  in  2  0=ACK 1=TIMEOUT 2=INIT 3=reserved, treated as no-op
evt_flow_id  in  FLOW_ID_W  target flow
evt_cum_ack  in  SEQ_W  cumulative ACK carried by the packet
evt_old_wnd_start  in  SEQ_W  window start before this ACK
evt_wnd_start  in  SEQ_W  window start after this ACK
evt_next_new  in  SEQ_W  next never-sent sequence number (recovery point)
out_valid  out  1  decision valid
out_ready  in  1  downstream accepts
out_flow_id  out  FLOW_ID_W  echoed flow id
out_mark_rtx  out  1  retransmit [out_rtx_start, out_rtx_end)
out_rtx_start  out  SEQ_W  first sequence to retransmit
out_rtx_end  out  SEQ_W  end of retransmit range (exclusive)
out_wnd_size  out  WIN_W  new congestion window
out_reset_rtx_timer  out  1  restart the flow's RTO timer
out_err  out  1  flow id >= NUM_FLOWS; no context touched

Behaviour:
- Handshake: evt_ready = ~out_valid | out_ready. On accept, all out_* register at the next edge, so latency is 1 cycle. When stalled (out_valid & ~out_ready) no context changes and the outputs hold.
- Context per flow:
  - state: OPEN=0, FAST_REC=1, RTO=2
  - wnd, ss_thresh, wnd_inc_cntr, dup_acks
  - recover (SEQ_W)
- Context read and write: read combinationally in the accept cycle, written at the same edge. Back-to-back events to the same flow therefore see updated state; no forwarding is needed.
- Reset: every flow gets state=OPEN, wnd=INIT_WND, ss_thresh=MAX_WND, all counters 0, recover=0. All outputs are 0 and out_valid=0.
- Serial compare: a > b iff (a-b) != 0 and MSB(a-b)=0, computed in SEQ_W-bit arithmetic. All sequence compares use this, so sequence wrap is handled.
- new_ack = evt_wnd_start > evt_old_wnd_start.
- dup_ack = ~new_ack & (evt_cum_ack == evt_old_wnd_start).
- acked = evt_wnd_start - evt_old_wnd_start, saturated to MAX_WND.
- half = max(wnd>>1, 2).
- Every wnd result is clamped to [1, MAX_WND].
- rtx range default: out_rtx_start = evt_wnd_start, out_rtx_end = evt_wnd_start + 1.
- out_reset_rtx_timer = new_ack for ACK events.
- ACK in OPEN:
  - new_ack: dup_acks=0. If wnd < ss_thresh then wnd+1 (slow start). Otherwise, if cntr == wnd then wnd+1 and cntr=0, else cntr+1.
  - dup_ack: dup_acks = min(dup_acks+1, MAX_DUP). When the new count == DUP_THRESH: mark_rtx=1, ss_thresh=half, wnd=half+DUP_THRESH, cntr=0, recover=evt_next_new, state becomes FAST_REC.
  - neither new nor dup: no change.
- ACK in FAST_REC:
  - dup_ack: wnd+1, dup_acks saturating.
  - new_ack with NEWRENO=1 and recover > evt_wnd_start (partial ACK): mark_rtx=1, wnd = max(wnd-acked+1, ss_thresh), dup_acks=0, state stays FAST_REC.
  - other new_ack: wnd=ss_thresh, dup_acks=0, cntr=0, state becomes OPEN.
- ACK in RTO:
  - new_ack: wnd+1 while wnd < ss_thresh, otherwise the congestion-avoidance rule. Leave to OPEN when evt_wnd_start == recover or evt_wnd_start > recover.
  - dup_ack: counter updates only; never triggers a retransmit.
- TIMEOUT (any state): ss_thresh=half, wnd=1, dup_acks=0, cntr=0, recover=evt_next_new, state becomes RTO. Outputs: mark_rtx=1, rtx range [evt_wnd_start, evt_next_new), reset_rtx_timer=1.
- INIT: flow context is set to its reset values; output has wnd=INIT_WND, all flags 0.
- type 3: output valid, all flags 0, out_wnd_size = current wnd, no update.
- flow id >= NUM_FLOWS: event accepted, out_err=1, flags 0, wnd output 0, no context write.

Test Plan:
- Reset, INIT flow 0, then 3 new ACKs with wnd_start advancing by 1 -> out_wnd_size 3,4,5 with reset_rtx_timer=1 each time.
- Flow 1 wnd=20, ss=256, then 3 dup ACKs (cum_ack=old_wnd_start=100) -> third output: mark_rtx=1, rtx [100,101), wnd=13, state FAST_REC; 4th dup ACK -> wnd=14.
- NEWRENO=1, recover=150, FAST_REC, then new ACK 100->120 -> partial: mark_rtx=1, rtx [120,121), wnd=max(14-20+1,10)=10. Then ACK to 150 -> wnd=10, OPEN.
- Timeout on flow 2 with wnd=9, next_new=300, wnd_start=250 -> wnd=1, ss=4, rtx [250,300). Following ACKs grow wnd 2,3,4; ACK reaching 300 -> OPEN.
- Wrap: old_wnd_start=0xFFFFFFFE, wnd_start=0x00000002 -> treated as new_ack, acked=4.
- Back-to-back dup ACKs to flow 3 with out_ready held low 5 cycles -> evt_ready=0 during the stall, outputs held, no lost or duplicated updates. Flow id 17 with NUM_FLOWS=16 -> out_err=1.

Source files
------------

// File: rtl/reno_cc_engine.sv
// Multi-flow TCP Reno/NewReno congestion-control engine.
// One event (ACK / TIMEOUT / INIT / no-op) is accepted per cycle. The addressed
// flow's context is read combinationally and rewritten at the accepting edge,
// and one decision is registered for the tx scheduler with 1-cycle latency.
module reno_cc_engine #(
    parameter int NUM_FLOWS  = 16,
    parameter int FLOW_ID_W  = $clog2(NUM_FLOWS),
    parameter int SEQ_W      = 32,
    parameter int WIN_W      = 9,
    parameter int MAX_WND    = 256,
    parameter int INIT_WND   = 2,
    parameter int DUP_THRESH = 3,
    parameter int MAX_DUP    = 15,
    parameter int NEWRENO    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 evt_valid,
    output logic                 evt_ready,
    input  logic [1:0]           evt_type,
    input  logic [FLOW_ID_W-1:0] evt_flow_id,
    input  logic [SEQ_W-1:0]     evt_cum_ack,
    input  logic [SEQ_W-1:0]     evt_old_wnd_start,
    input  logic [SEQ_W-1:0]     evt_wnd_start,
    input  logic [SEQ_W-1:0]     evt_next_new,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [FLOW_ID_W-1:0] out_flow_id,
    output logic                 out_mark_rtx,
    output logic [SEQ_W-1:0]     out_rtx_start,
    output logic [SEQ_W-1:0]     out_rtx_end,
    output logic [WIN_W-1:0]     out_wnd_size,
    output logic                 out_reset_rtx_timer,
    output logic                 out_err
);

    localparam int IDX_W = (NUM_FLOWS > 1) ? $clog2(NUM_FLOWS) : 1;
    localparam logic [1:0] EVT_ACK     = 2'd0;
    localparam logic [1:0] EVT_TIMEOUT = 2'd1;
    localparam logic [1:0] EVT_INIT    = 2'd2;
    localparam logic [WIN_W-1:0] MAX_WND_W    = WIN_W'(MAX_WND);
    localparam logic [WIN_W-1:0] INIT_WND_W   = WIN_W'(INIT_WND);
    localparam logic [WIN_W-1:0] DUP_THRESH_W = WIN_W'(DUP_THRESH);
    localparam logic [WIN_W-1:0] MAX_DUP_W    = WIN_W'(MAX_DUP);
    localparam logic [WIN_W-1:0] ONE_W        = WIN_W'(1);
    localparam logic [WIN_W-1:0] TWO_W        = WIN_W'(2);
    localparam logic signed [WIN_W+1:0] ONE_S     = (WIN_W+2)'(1);
    localparam logic signed [WIN_W+1:0] MAX_WND_S = (WIN_W+2)'(MAX_WND);
    localparam logic [SEQ_W-1:0] MAX_WND_SEQ  = SEQ_W'(MAX_WND);
    localparam logic [SEQ_W-1:0] SEQ_ONE      = SEQ_W'(1);

    typedef enum logic [1:0] {
        ST_OPEN     = 2'd0,
        ST_FAST_REC = 2'd1,
        ST_RTO      = 2'd2
    } cc_state_e;

    // Serial-number compare: a is ahead of b within half the sequence space.
    function automatic logic seq_gt(input logic [SEQ_W-1:0] a, input logic [SEQ_W-1:0] b);
        logic [SEQ_W-1:0] diff;
        diff = a - b;
        return (diff != '0) && !diff[SEQ_W-1];
    endfunction

    // Zero-extend a window value into signed headroom so subtraction can go negative.
    function automatic logic signed [WIN_W+1:0] to_s(input logic [WIN_W-1:0] x);
        return $signed({2'b00, x});
    endfunction

    // Every window result ends up in [1, MAX_WND].
    function automatic logic [WIN_W-1:0] clamp_wnd(input logic signed [WIN_W+1:0] x);
        if (x < ONE_S) begin
            return ONE_W;
        end else if (x > MAX_WND_S) begin
            return MAX_WND_W;
        end else begin
            return x[WIN_W-1:0];
        end
    endfunction

    // Per-flow context array
    cc_state_e        state_q   [NUM_FLOWS];
    logic [WIN_W-1:0] wnd_q     [NUM_FLOWS];
    logic [WIN_W-1:0] ss_q      [NUM_FLOWS];
    logic [WIN_W-1:0] cntr_q    [NUM_FLOWS];
    logic [WIN_W-1:0] dup_q     [NUM_FLOWS];
    logic [SEQ_W-1:0] recover_q [NUM_FLOWS];

    cc_state_e        state_d;
    logic [WIN_W-1:0] wnd_d, ss_d, cntr_d, dup_d;
    logic [SEQ_W-1:0] recover_d;
    logic             ctx_we_s;

    logic                 out_valid_q, out_mark_rtx_q, out_reset_rtx_timer_q, out_err_q;
    logic [FLOW_ID_W-1:0] out_flow_id_q;
    logic [SEQ_W-1:0]     out_rtx_start_q, out_rtx_end_q;
    logic [WIN_W-1:0]     out_wnd_size_q;
    logic                 out_mark_rtx_d, out_reset_rtx_timer_d, out_err_d;
    logic [SEQ_W-1:0]     out_rtx_start_d, out_rtx_end_d;
    logic [WIN_W-1:0]     out_wnd_size_d;

    logic             accept_s, flow_ok_s, new_ack_s, dup_ack_s;
    logic [IDX_W-1:0] idx_s;
    logic [SEQ_W-1:0] adv_s;
    logic [WIN_W-1:0] acked_s, half_s, dup_sat_s, grow_wnd_s, grow_cntr_s;
    logic signed [WIN_W+1:0] part_s;
    cc_state_e        cur_state_s;
    logic [WIN_W-1:0] cur_wnd_s, cur_ss_s, cur_cntr_s, cur_dup_s;
    logic [SEQ_W-1:0] cur_recover_s;

    assign evt_ready     = ~out_valid_q | out_ready;
    assign accept_s      = evt_valid & evt_ready;
    assign flow_ok_s     = (32'(evt_flow_id) < 32'(NUM_FLOWS));
    assign idx_s         = evt_flow_id[IDX_W-1:0];
    assign cur_state_s   = state_q[idx_s];
    assign cur_wnd_s     = wnd_q[idx_s];
    assign cur_ss_s      = ss_q[idx_s];
    assign cur_cntr_s    = cntr_q[idx_s];
    assign cur_dup_s     = dup_q[idx_s];
    assign cur_recover_s = recover_q[idx_s];

    // ACK classification and the derived quantities shared by all states
    always_comb begin
        new_ack_s = seq_gt(evt_wnd_start, evt_old_wnd_start);
        dup_ack_s = ~new_ack_s & (evt_cum_ack == evt_old_wnd_start);
        adv_s     = evt_wnd_start - evt_old_wnd_start;
        acked_s   = (adv_s > MAX_WND_SEQ) ? MAX_WND_W : adv_s[WIN_W-1:0];
        half_s    = ((cur_wnd_s >> 1) < TWO_W) ? TWO_W : (cur_wnd_s >> 1);
        dup_sat_s = (cur_dup_s >= MAX_DUP_W) ? MAX_DUP_W : (cur_dup_s + ONE_W);
        part_s    = to_s(cur_wnd_s) - to_s(acked_s) + ONE_S;
        if (cur_wnd_s < cur_ss_s) begin
            grow_wnd_s  = clamp_wnd(to_s(cur_wnd_s) + ONE_S);
            grow_cntr_s = cur_cntr_s;
        end else if (cur_cntr_s == cur_wnd_s) begin
            grow_wnd_s  = clamp_wnd(to_s(cur_wnd_s) + ONE_S);
            grow_cntr_s = '0;
        end else begin
            grow_wnd_s  = cur_wnd_s;
            grow_cntr_s = cur_cntr_s + ONE_W;
        end
    end

    // Per-event context next-state and decision outputs
    always_comb begin
        state_d               = cur_state_s;
        wnd_d                 = cur_wnd_s;
        ss_d                  = cur_ss_s;
        cntr_d                = cur_cntr_s;
        dup_d                 = cur_dup_s;
        recover_d             = cur_recover_s;
        ctx_we_s              = 1'b0;
        out_mark_rtx_d        = 1'b0;
        out_rtx_start_d       = evt_wnd_start;
        out_rtx_end_d         = evt_wnd_start + SEQ_ONE;
        out_reset_rtx_timer_d = 1'b0;
        out_err_d             = 1'b0;
        if (!flow_ok_s) begin
            out_err_d = 1'b1;
        end else begin
            case (evt_type)
                EVT_ACK: begin
                    ctx_we_s              = 1'b1;
                    out_reset_rtx_timer_d = new_ack_s;
                    case (cur_state_s)
                        ST_OPEN: begin
                            if (new_ack_s) begin
                                dup_d  = '0;
                                wnd_d  = grow_wnd_s;
                                cntr_d = grow_cntr_s;
                            end else if (dup_ack_s) begin
                                dup_d = dup_sat_s;
                                if (dup_sat_s == DUP_THRESH_W) begin
                                    out_mark_rtx_d = 1'b1;
                                    ss_d           = half_s;
                                    wnd_d          = clamp_wnd(to_s(half_s) + to_s(DUP_THRESH_W));
                                    cntr_d         = '0;
                                    recover_d      = evt_next_new;
                                    state_d        = ST_FAST_REC;
                                end else begin
                                    state_d = ST_OPEN;
                                end
                            end else begin
                                state_d = ST_OPEN;
                            end
                        end
                        ST_FAST_REC: begin
                            if (dup_ack_s) begin
                                wnd_d = clamp_wnd(to_s(cur_wnd_s) + ONE_S);
                                dup_d = dup_sat_s;
                            end else if (new_ack_s) begin
                                dup_d = '0;
                                if ((NEWRENO != 0) && seq_gt(cur_recover_s, evt_wnd_start)) begin
                                    // partial ACK: retransmit the next hole, deflate window
                                    out_mark_rtx_d = 1'b1;
                                    wnd_d = (part_s < to_s(cur_ss_s)) ? clamp_wnd(to_s(cur_ss_s))
                                                                      : clamp_wnd(part_s);
                                end else begin
                                    wnd_d   = clamp_wnd(to_s(cur_ss_s));
                                    cntr_d  = '0;
                                    state_d = ST_OPEN;
                                end
                            end else begin
                                state_d = ST_FAST_REC;
                            end
                        end
                        ST_RTO: begin
                            if (new_ack_s) begin
                                dup_d  = '0;
                                wnd_d  = grow_wnd_s;
                                cntr_d = grow_cntr_s;
                                if ((evt_wnd_start == cur_recover_s) ||
                                    seq_gt(evt_wnd_start, cur_recover_s)) begin
                                    state_d = ST_OPEN;
                                end else begin
                                    state_d = ST_RTO;
                                end
                            end else if (dup_ack_s) begin
                                dup_d = dup_sat_s;
                            end else begin
                                state_d = ST_RTO;
                            end
                        end
                        default: begin
                            state_d = ST_OPEN;
                        end
                    endcase
                end
                EVT_TIMEOUT: begin
                    ctx_we_s              = 1'b1;
                    ss_d                  = half_s;
                    wnd_d                 = ONE_W;
                    dup_d                 = '0;
                    cntr_d                = '0;
                    recover_d             = evt_next_new;
                    state_d               = ST_RTO;
                    out_mark_rtx_d        = 1'b1;
                    out_rtx_end_d         = evt_next_new;
                    out_reset_rtx_timer_d = 1'b1;
                end
                EVT_INIT: begin
                    ctx_we_s  = 1'b1;
                    state_d   = ST_OPEN;
                    wnd_d     = INIT_WND_W;
                    ss_d      = MAX_WND_W;
                    cntr_d    = '0;
                    dup_d     = '0;
                    recover_d = '0;
                end
                default: begin
                    ctx_we_s = 1'b0;
                end
            endcase
        end
        out_wnd_size_d = flow_ok_s ? wnd_d : '0;
    end

    // Context array: reset all flows, otherwise write the accepted flow
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_FLOWS; i++) begin
                state_q[i]   <= ST_OPEN;
                wnd_q[i]     <= INIT_WND_W;
                ss_q[i]      <= MAX_WND_W;
                cntr_q[i]    <= '0;
                dup_q[i]     <= '0;
                recover_q[i] <= '0;
            end
        end else if (accept_s && flow_ok_s && ctx_we_s) begin
            state_q[idx_s]   <= state_d;
            wnd_q[idx_s]     <= wnd_d;
            ss_q[idx_s]      <= ss_d;
            cntr_q[idx_s]    <= cntr_d;
            dup_q[idx_s]     <= dup_d;
            recover_q[idx_s] <= recover_d;
        end
    end

    // Decision register: load on accept, drop valid once consumed, hold while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q           <= 1'b0;
            out_flow_id_q         <= '0;
            out_mark_rtx_q        <= 1'b0;
            out_rtx_start_q       <= '0;
            out_rtx_end_q         <= '0;
            out_wnd_size_q        <= '0;
            out_reset_rtx_timer_q <= 1'b0;
            out_err_q             <= 1'b0;
        end else if (accept_s) begin
            out_valid_q           <= 1'b1;
            out_flow_id_q         <= evt_flow_id;
            out_mark_rtx_q        <= out_mark_rtx_d;
            out_rtx_start_q       <= out_rtx_start_d;
            out_rtx_end_q         <= out_rtx_end_d;
            out_wnd_size_q        <= out_wnd_size_d;
            out_reset_rtx_timer_q <= out_reset_rtx_timer_d;
            out_err_q             <= out_err_d;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid           = out_valid_q;
    assign out_flow_id         = out_flow_id_q;
    assign out_mark_rtx        = out_mark_rtx_q;
    assign out_rtx_start       = out_rtx_start_q;
    assign out_rtx_end         = out_rtx_end_q;
    assign out_wnd_size        = out_wnd_size_q;
    assign out_reset_rtx_timer = out_reset_rtx_timer_q;
    assign out_err             = out_err_q;

endmodule

// File: tb/tb_reno_cc_engine.sv
// Directed bench for reno_cc_engine: hand-computed expected decisions per event.
module tb_reno_cc_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        evt_valid, evt_ready;
    logic [1:0]  evt_type;
    logic [4:0]  evt_flow_id;
    logic [31:0] evt_cum_ack, evt_old_wnd_start, evt_wnd_start, evt_next_new;
    logic        out_valid, out_ready;
    logic [4:0]  out_flow_id;
    logic        out_mark_rtx;
    logic [31:0] out_rtx_start, out_rtx_end;
    logic [8:0]  out_wnd_size;
    logic        out_reset_rtx_timer, out_err;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    reno_cc_engine #(.NUM_FLOWS(16), .FLOW_ID_W(5)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .evt_valid           (evt_valid),
        .evt_ready           (evt_ready),
        .evt_type            (evt_type),
        .evt_flow_id         (evt_flow_id),
        .evt_cum_ack         (evt_cum_ack),
        .evt_old_wnd_start   (evt_old_wnd_start),
        .evt_wnd_start       (evt_wnd_start),
        .evt_next_new        (evt_next_new),
        .out_valid           (out_valid),
        .out_ready           (out_ready),
        .out_flow_id         (out_flow_id),
        .out_mark_rtx        (out_mark_rtx),
        .out_rtx_start       (out_rtx_start),
        .out_rtx_end         (out_rtx_end),
        .out_wnd_size        (out_wnd_size),
        .out_reset_rtx_timer (out_reset_rtx_timer),
        .out_err             (out_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            miss_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one event, wait (bounded) for acceptance, return #1 after the accepting edge.
    task automatic send(input logic [1:0] t, input logic [4:0] f, input logic [31:0] cum,
                        input logic [31:0] old, input logic [31:0] ws, input logic [31:0] nn);
        int n;
        @(negedge clk);
        evt_type = t; evt_flow_id = f; evt_cum_ack = cum;
        evt_old_wnd_start = old; evt_wnd_start = ws; evt_next_new = nn;
        evt_valid = 1'b1;
        n = 0;
        while (!evt_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!evt_ready) chk("accept_timeout", 64'(evt_ready), 64'd1);
        @(posedge clk);
        #1;
        evt_valid = 1'b0;
    endtask

    task automatic ack(input logic [4:0] f, input logic [31:0] old, input logic [31:0] ws);
        send(2'd0, f, ws, old, ws, 32'd0);
    endtask

    task automatic dup(input logic [4:0] f, input logic [31:0] s, input logic [31:0] nn);
        send(2'd0, f, s, s, s, nn);
    endtask

    // Check the core decision fields of the current output.
    task automatic chk_out(input string tag, input logic mark, input logic [8:0] wnd,
                           input logic tmr);
        chk({tag, ".valid"}, 64'(out_valid), 64'd1);
        chk({tag, ".mark"},  64'(out_mark_rtx), 64'(mark));
        chk({tag, ".wnd"},   64'(out_wnd_size), 64'(wnd));
        chk({tag, ".tmr"},   64'(out_reset_rtx_timer), 64'(tmr));
    endtask

    task automatic chk_rng(input string tag, input logic [31:0] rs, input logic [31:0] re);
        chk({tag, ".rs"}, 64'(out_rtx_start), 64'(rs));
        chk({tag, ".re"}, 64'(out_rtx_end), 64'(re));
    endtask

    initial begin
        rst = 1'b1; evt_valid = 1'b0; evt_type = 2'd0; evt_flow_id = 5'd0;
        evt_cum_ack = 32'd0; evt_old_wnd_start = 32'd0; evt_wnd_start = 32'd0;
        evt_next_new = 32'd0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst.valid", 64'(out_valid), 64'd0);
        chk("rst.wnd",   64'(out_wnd_size), 64'd0);
        chk("rst.mark",  64'(out_mark_rtx), 64'd0);
        chk("rst.err",   64'(out_err), 64'd0);
        chk("rst.ready", 64'(evt_ready), 64'd1);

        // Flow 0: INIT then slow start 3,4,5
        send(2'd2, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        chk_out("f0.init", 1'b0, 9'd2, 1'b0);
        chk("f0.init.flow", 64'(out_flow_id), 64'd0);
        ack(5'd0, 32'd0, 32'd1);  chk_out("f0.ack1", 1'b0, 9'd3, 1'b1);
        ack(5'd0, 32'd1, 32'd2);  chk_out("f0.ack2", 1'b0, 9'd4, 1'b1);
        ack(5'd0, 32'd2, 32'd3);  chk_out("f0.ack3", 1'b0, 9'd5, 1'b1);
        send(2'd3, 5'd0, 32'd9, 32'd3, 32'd7, 32'd0);
        chk_out("f0.noop", 1'b0, 9'd5, 1'b0);

        // Flow 1: grow to 20, fast retransmit, NewReno partial then full ACK
        send(2'd2, 5'd1, 32'd0, 32'd0, 32'd0, 32'd0);
        for (int k = 82; k < 100; k++) ack(5'd1, 32'(k), 32'(k + 1));
        chk_out("f1.grow", 1'b0, 9'd20, 1'b1);
        dup(5'd1, 32'd100, 32'd150); chk_out("f1.dup1", 1'b0, 9'd20, 1'b0);
        dup(5'd1, 32'd100, 32'd150); chk_out("f1.dup2", 1'b0, 9'd20, 1'b0);
        dup(5'd1, 32'd100, 32'd150); chk_out("f1.dup3", 1'b1, 9'd13, 1'b0);
        chk_rng("f1.dup3", 32'd100, 32'd101);
        dup(5'd1, 32'd100, 32'd150); chk_out("f1.dup4", 1'b0, 9'd14, 1'b0);
        ack(5'd1, 32'd100, 32'd120); chk_out("f1.partial", 1'b1, 9'd10, 1'b1);
        chk_rng("f1.partial", 32'd120, 32'd121);
        ack(5'd1, 32'd120, 32'd150); chk_out("f1.full", 1'b0, 9'd10, 1'b1);
        dup(5'd1, 32'd150, 32'd150); chk_out("f1.open_dup", 1'b0, 9'd10, 1'b0);

        // Flow 2: timeout at wnd 9, regrowth in RTO, exit to OPEN, then fast retransmit
        send(2'd2, 5'd2, 32'd0, 32'd0, 32'd0, 32'd0);
        for (int k = 200; k < 207; k++) ack(5'd2, 32'(k), 32'(k + 1));
        chk_out("f2.grow", 1'b0, 9'd9, 1'b1);
        send(2'd1, 5'd2, 32'd250, 32'd250, 32'd250, 32'd300);
        chk_out("f2.tmo", 1'b1, 9'd1, 1'b1);
        chk_rng("f2.tmo", 32'd250, 32'd300);
        ack(5'd2, 32'd250, 32'd260); chk_out("f2.rto1", 1'b0, 9'd2, 1'b1);
        ack(5'd2, 32'd260, 32'd270); chk_out("f2.rto2", 1'b0, 9'd3, 1'b1);
        ack(5'd2, 32'd270, 32'd280); chk_out("f2.rto3", 1'b0, 9'd4, 1'b1);
        ack(5'd2, 32'd280, 32'd300); chk_out("f2.exit", 1'b0, 9'd4, 1'b1);
        dup(5'd2, 32'd300, 32'd400); chk_out("f2.dup1", 1'b0, 9'd4, 1'b0);
        dup(5'd2, 32'd300, 32'd400);
        dup(5'd2, 32'd300, 32'd400); chk_out("f2.dup3", 1'b1, 9'd5, 1'b0);
        chk_rng("f2.dup3", 32'd300, 32'd301);

        // Flow 5: dup ACKs in RTO never retransmit
        send(2'd2, 5'd5, 32'd0, 32'd0, 32'd0, 32'd0);
        send(2'd1, 5'd5, 32'd500, 32'd500, 32'd500, 32'd600);
        chk_out("f5.tmo", 1'b1, 9'd1, 1'b1);
        dup(5'd5, 32'd500, 32'd600);
        dup(5'd5, 32'd500, 32'd600);
        dup(5'd5, 32'd500, 32'd600); chk_out("f5.rto_dup3", 1'b0, 9'd1, 1'b0);

        // Flow 4: sequence wrap
        send(2'd2, 5'd4, 32'd0, 32'd0, 32'd0, 32'd0);
        ack(5'd4, 32'hFFFF_FFFE, 32'h0000_0002); chk_out("f4.wrap", 1'b0, 9'd3, 1'b1);
        send(2'd0, 5'd4, 32'd5, 32'd2, 32'hFFFF_FFFE, 32'd0);
        chk_out("f4.back", 1'b0, 9'd3, 1'b0);
        dup(5'd4, 32'hFFFF_FFFE, 32'h10);
        dup(5'd4, 32'hFFFF_FFFE, 32'h10);
        dup(5'd4, 32'hFFFF_FFFE, 32'h10); chk_out("f4.dup3", 1'b1, 9'd5, 1'b0);
        chk_rng("f4.dup3", 32'hFFFF_FFFE, 32'hFFFF_FFFF);
        dup(5'd4, 32'hFFFF_FFFE, 32'h10);
        dup(5'd4, 32'hFFFF_FFFE, 32'h10); chk_out("f4.dup5", 1'b0, 9'd7, 1'b0);
        ack(5'd4, 32'hFFFF_FFFE, 32'h0000_0002); chk_out("f4.partial", 1'b1, 9'd4, 1'b1);
        chk_rng("f4.partial", 32'd2, 32'd3);

        // Flow 3: stall with a pending dup ACK, no lost or duplicated update
        send(2'd2, 5'd3, 32'd0, 32'd0, 32'd0, 32'd0);
        dup(5'd3, 32'd400, 32'd500); chk_out("f3.dup1", 1'b0, 9'd2, 1'b0);
        @(negedge clk);
        out_ready = 1'b0;
        evt_type = 2'd0; evt_flow_id = 5'd3; evt_cum_ack = 32'd400;
        evt_old_wnd_start = 32'd400; evt_wnd_start = 32'd400; evt_next_new = 32'd500;
        evt_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk("f3.stall.ready", 64'(evt_ready), 64'd0);
            chk("f3.stall.wnd",   64'(out_wnd_size), 64'd2);
        end
        chk("f3.stall.valid", 64'(out_valid), 64'd1);
        chk("f3.stall.flow",  64'(out_flow_id), 64'd3);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        evt_valid = 1'b0;
        chk_out("f3.dup2", 1'b0, 9'd2, 1'b0);
        dup(5'd3, 32'd400, 32'd500); chk_out("f3.dup3", 1'b1, 9'd5, 1'b0);

        // Out-of-range flow id: error, no context write (flow 1 alias untouched)
        send(2'd2, 5'd17, 32'd0, 32'd0, 32'd0, 32'd0);
        chk("f17.err",  64'(out_err), 64'd1);
        chk("f17.wnd",  64'(out_wnd_size), 64'd0);
        chk("f17.mark", 64'(out_mark_rtx), 64'd0);
        chk("f17.flow", 64'(out_flow_id), 64'd17);
        send(2'd3, 5'd1, 32'd0, 32'd0, 32'd0, 32'd0);
        chk_out("f1.after_err", 1'b0, 9'd10, 1'b0);
        chk("f1.after_err.err", 64'(out_err), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
